// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter
// Shares the single frame-buffer RAM port between LCD scan-out reads and a
// buffered write stream. Scan-out always wins the port; writes wait in a small
// FIFO and drain into cycles with no scan request.
// Optional feature: define VRAM_ARB_STAT_EN to add saturating statistics
// counters (oSTAT_WR_CNT, oSTAT_STALL_CNT).
//
// state  | meaning
// S_IDLE | no RAM access this cycle; RAM address holds its last value
// S_SCAN | scan-out read issued to the RAM
// S_WR   | FIFO head popped and written to the RAM
module vram_port_arbiter #(
  parameter int AW      = 17,
  parameter int DW      = 16,
  parameter int DEPTH   = 96000,
  parameter int FIFO_AW = 3,
  parameter int RD_LAT  = 1
) (
  input  logic              iACLK,
  input  logic              inRST,
  input  logic              iSCAN_REQ,
  input  logic [AW-1:0]     iSCAN_ADDR,
  output logic [DW-1:0]     oSCAN_DATA,
  output logic              oSCAN_VALID,
  input  logic              iWR_VALID,
  output logic              oWR_READY,
  input  logic [AW-1:0]     iWR_ADDR,
  input  logic [DW-1:0]     iWR_DATA,
  input  logic [DW/8-1:0]   iWR_BE,
  output logic [AW-1:0]     oRAM_ADDR,
  output logic              oRAM_WE,
  output logic [DW-1:0]     oRAM_WDATA,
  output logic [DW/8-1:0]   oRAM_BE,
  input  logic [DW-1:0]     iRAM_RDATA,
  output logic [FIFO_AW:0]  oFIFO_LVL,
  output logic              oERR,
  input  logic              iERR_CLR
`ifdef VRAM_ARB_STAT_EN
  ,
  output logic [15:0]       oSTAT_WR_CNT,
  output logic [15:0]       oSTAT_STALL_CNT
`endif
);

  localparam int BW = DW / 8;
  localparam int FD = 1 << FIFO_AW;
  // One extra bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t state_q, state_nxt;

  logic [AW-1:0]      fifo_addr [FD];
  logic [DW-1:0]      fifo_data [FD];
  logic [BW-1:0]      fifo_be   [FD];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count, count_nxt;
  logic               wr_ready;
  logic               fifo_empty, range_bad, accept, push, pop;

  logic [AW-1:0]      addr_nxt;
  logic               we_nxt;
  logic [DW-1:0]      wdata_nxt;
  logic [BW-1:0]      be_nxt;

  logic [RD_LAT-1:0]  vpipe;
  logic [DW-1:0]      scan_hold;
  logic               err_q;

  assign fifo_empty = (count == '0);
  assign range_bad  = ({1'b0, iWR_ADDR} >= DEPTH_W);
  assign accept     = iWR_VALID & wr_ready;
  assign push       = accept & ~range_bad;

  assign oWR_READY   = wr_ready;
  assign oFIFO_LVL   = count;
  assign oERR        = err_q;
  assign oSCAN_VALID = vpipe[RD_LAT-1];
  assign oSCAN_DATA  = oSCAN_VALID ? iRAM_RDATA : scan_hold;

  // Grant decision: scan first, then FIFO head, otherwise idle with RAM outputs held.
  always_comb begin
    state_nxt = S_IDLE;
    pop       = 1'b0;
    addr_nxt  = oRAM_ADDR;
    we_nxt    = 1'b0;
    wdata_nxt = oRAM_WDATA;
    be_nxt    = oRAM_BE;
    if (iSCAN_REQ) begin
      state_nxt = S_SCAN;
      addr_nxt  = iSCAN_ADDR;
    end else if (!fifo_empty) begin
      state_nxt = S_WR;
      pop       = 1'b1;
      addr_nxt  = fifo_addr[rd_ptr];
      we_nxt    = 1'b1;
      wdata_nxt = fifo_data[rd_ptr];
      be_nxt    = fifo_be[rd_ptr];
    end
  end

  // Grant state and the registered RAM port.
  always_ff @(posedge iACLK) begin
    if (!inRST) begin
      state_q    <= S_IDLE;
      oRAM_ADDR  <= '0;
      oRAM_WE    <= 1'b0;
      oRAM_WDATA <= '0;
      oRAM_BE    <= '0;
    end else begin
      state_q    <= state_nxt;
      oRAM_ADDR  <= addr_nxt;
      oRAM_WE    <= we_nxt;
      oRAM_WDATA <= wdata_nxt;
      oRAM_BE    <= be_nxt;
    end
  end

  // Occupancy update; a simultaneous push and pop leaves the level unchanged.
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + (FIFO_AW+1)'(1);
    end else if (pop && !push) begin
      count_nxt = count - (FIFO_AW+1)'(1);
    end
  end

  // FIFO pointers, level and ready; ready mirrors "not full" of the registered level.
  always_ff @(posedge iACLK) begin
    if (!inRST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wr_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      count    <= count_nxt;
      wr_ready <= ~count_nxt[FIFO_AW];
    end
  end

  // FIFO storage; contents need no reset because the level gates every read.
  always_ff @(posedge iACLK) begin
    if (push) begin
      fifo_addr[wr_ptr] <= iWR_ADDR;
      fifo_data[wr_ptr] <= iWR_DATA;
      fifo_be[wr_ptr]   <= iWR_BE;
    end
  end

  // Scan valid pipeline: one stage for the address register plus RD_LAT for the RAM.
  always_ff @(posedge iACLK) begin
    if (!inRST) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= (state_q == S_SCAN);
      for (int i = 1; i < RD_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
      end
    end
  end

  // Hold the last delivered scan word between valids.
  always_ff @(posedge iACLK) begin
    if (!inRST) begin
      scan_hold <= '0;
    end else if (oSCAN_VALID) begin
      scan_hold <= iRAM_RDATA;
    end
  end

  // Sticky out-of-range error; a new error beats a same-cycle clear.
  always_ff @(posedge iACLK) begin
    if (!inRST) begin
      err_q <= 1'b0;
    end else if (accept && range_bad) begin
      err_q <= 1'b1;
    end else if (iERR_CLR) begin
      err_q <= 1'b0;
    end
  end

`ifdef VRAM_ARB_STAT_EN
  logic [15:0] stat_wr, stat_stall;

  // Saturating statistics; iERR_CLR also clears them.
  always_ff @(posedge iACLK) begin
    if (!inRST || iERR_CLR) begin
      stat_wr    <= '0;
      stat_stall <= '0;
    end else begin
      if (pop && (stat_wr != 16'hFFFF)) stat_wr <= stat_wr + 16'd1;
      if (iWR_VALID && !wr_ready && (stat_stall != 16'hFFFF)) stat_stall <= stat_stall + 16'd1;
    end
  end

  assign oSTAT_WR_CNT    = stat_wr;
  assign oSTAT_STALL_CNT = stat_stall;
`endif

endmodule
